// File: rtl/cms_trace_pkg.sv
// Shared types and constants for the CMS trace receive path.
// A trace beat is {pc, instr} on tdata with tlast carried alongside.
package cms_trace_pkg;

  localparam int XLEN            = 64;
  localparam int TRACE_INSTR_LSB = 0;
  localparam int TRACE_PC_LSB    = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            last;
  } trace_beat_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/cms_trace_fifo.sv
// Synchronous beat FIFO with a registered head entry and registered full/empty flags.
// Capacity counts the head, so DEPTH accepted-but-unpopped entries make it full.
module cms_trace_fifo
  import cms_trace_pkg::*;
#(
  parameter int WIDTH = 97,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             head_valid,
  input  logic             head_ready,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    rd_ptr_nxt_s;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_pop_s;
  logic [CW-1:0]    count_nxt_s;
  logic             push_s;
  logic             pop_s;
  logic             ready_r;
  logic             valid_r;
  logic [WIDTH-1:0] head_r;

  // Handshakes and next occupancy; ready comes from a register so it never sees a same-cycle pop.
  always_comb begin
    push_s       = push_valid && ready_r;
    pop_s        = valid_r && head_ready;
    count_pop_s  = count_r - CW'(pop_s);
    count_nxt_s  = count_pop_s + CW'(push_s);
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + AW'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
  end

  // Storage array, written on every accepted beat.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, flags and the head register; the head holds its value once the FIFO drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      ready_r  <= 1'b0;
      valid_r  <= 1'b0;
      head_r   <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      ready_r  <= (count_nxt_s != CW'(DEPTH));
      valid_r  <= (count_nxt_s != CW'(0));
      if (count_nxt_s != CW'(0)) begin
        // With nothing left behind the pop, the incoming beat becomes the head directly.
        head_r <= (count_pop_s == CW'(0)) ? push_data : mem_r[rd_ptr_nxt_s];
      end
    end
  end

  assign push_ready = ready_r;
  assign head_valid = valid_r;
  assign head_data  = head_r;

endmodule

// File: rtl/cms_trace_axis_receiver.sv
// AXI-Stream sink for trace beats: buffers them, unpacks {pc, instr}, checks tlast
// framing against tlast_interval and keeps beat/packet/framing-error counters.
module cms_trace_axis_receiver
  import cms_trace_pkg::*;
#(
  parameter int XLEN           = cms_trace_pkg::XLEN,
  parameter int AXI_DATA_WIDTH = XLEN + 32,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      S_AXIS_tvalid,
  output logic                      S_AXIS_tready,
  input  logic [AXI_DATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                      S_AXIS_tlast,
  input  logic [31:0]               tlast_interval,
  input  logic                      clear,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [31:0]               out_instr,
  output logic                      out_last,
  output logic [31:0]               beat_count,
  output logic [31:0]               packet_count,
  output logic                      frame_err,
  output logic [31:0]               frame_err_count
);

  localparam int BEAT_W = AXI_DATA_WIDTH + 1;

  logic [BEAT_W-1:0] head_s;
  logic              accept_s;
  logic [31:0]       pos_inc_s;
  logic              pos_hit_s;
  logic              beat_err_s;
  logic [31:0]       pos_nxt_s;
  logic [31:0]       beat_pos_r;
  logic [31:0]       beat_count_r;
  logic [31:0]       packet_count_r;
  logic              frame_err_r;
  logic [31:0]       frame_err_count_r;

  cms_trace_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (S_AXIS_tvalid),
    .push_ready (S_AXIS_tready),
    .push_data  ({S_AXIS_tdata, S_AXIS_tlast}),
    .head_valid (out_valid),
    .head_ready (out_ready),
    .head_data  (head_s)
  );

  assign accept_s  = S_AXIS_tvalid && S_AXIS_tready;
  assign out_last  = head_s[0];
  assign out_instr = head_s[1 + TRACE_INSTR_LSB +: 32];
  assign out_pc    = head_s[1 + TRACE_PC_LSB +: XLEN];

  // Framing decision for the beat being accepted this cycle.
  always_comb begin
    pos_inc_s  = beat_pos_r + 32'd1;
    pos_hit_s  = (pos_inc_s == tlast_interval);
    beat_err_s = 1'b0;
    pos_nxt_s  = beat_pos_r;
    if (!accept_s) begin
      pos_nxt_s = beat_pos_r;
    end else if (tlast_interval == 32'd0) begin
      pos_nxt_s = S_AXIS_tlast ? 32'd0 : pos_inc_s;
    end else if (S_AXIS_tlast) begin
      beat_err_s = !pos_hit_s;
      pos_nxt_s  = 32'd0;
    end else if (pos_hit_s) begin
      // Missing tlast: flag it and restart the count so the next packet can line up.
      beat_err_s = 1'b1;
      pos_nxt_s  = 32'd0;
    end else begin
      pos_nxt_s = pos_inc_s;
    end
  end

  // Packet position and statistics; clear zeroes statistics but never the position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_pos_r        <= 32'd0;
      beat_count_r      <= 32'd0;
      packet_count_r    <= 32'd0;
      frame_err_r       <= 1'b0;
      frame_err_count_r <= 32'd0;
    end else begin
      beat_pos_r <= pos_nxt_s;
      if (clear) begin
        beat_count_r      <= 32'd0;
        packet_count_r    <= 32'd0;
        frame_err_r       <= 1'b0;
        frame_err_count_r <= 32'd0;
      end else if (accept_s) begin
        beat_count_r <= beat_count_r + 32'd1;
        if (S_AXIS_tlast) begin
          packet_count_r <= packet_count_r + 32'd1;
        end
        if (beat_err_s) begin
          frame_err_r       <= 1'b1;
          frame_err_count_r <= sat_inc32(frame_err_count_r);
        end
      end
    end
  end

  assign beat_count      = beat_count_r;
  assign packet_count    = packet_count_r;
  assign frame_err       = frame_err_r;
  assign frame_err_count = frame_err_count_r;

endmodule
